// File: rtl/alu_digit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_digit_serial_pkg
// Purpose  : ALU control encodings and FSM state type shared by the
//            digit-serial ALU, its slice and its bus interface.
// Revision : 1.0
// ============================================================================
package alu_digit_serial_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_digit_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_digit_serial_if
// Purpose  : Operand/result handshake bundle between producer, ALU and consumer.
// Revision : 1.0
// ============================================================================
interface alu_digit_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_digit_serial_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_digit_serial_slice
// Purpose  : Combinational DIGIT-wide ALU slice (AND / OR / sum with carry).
// Revision : 1.0
// ============================================================================
module alu_digit_serial_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  input  logic             ainvert_i,
  input  logic             binvert_i,
  input  logic [1:0]       operation_i,
  output logic [DIGIT-1:0] y_o,
  output logic             cout_o,
  output logic             msb_sum_o
);
  logic [DIGIT-1:0] w_ai;
  logic [DIGIT-1:0] w_bi;
  logic [DIGIT:0]   w_sum;

  assign w_ai  = ainvert_i ? ~a_i : a_i;
  assign w_bi  = binvert_i ? ~b_i : b_i;
  assign w_sum = {1'b0, w_ai} + {1'b0, w_bi} + (DIGIT+1)'(cin_i);

  assign cout_o    = w_sum[DIGIT];
  assign msb_sum_o = w_sum[DIGIT-1];

  // Operation 11 (SLT) also yields the sum; the top turns it into the less bit.
  always_comb begin
    y_o = '0;
    unique case (operation_i)
      2'b00:   y_o = w_ai & w_bi;
      2'b01:   y_o = w_ai | w_bi;
      default: y_o = w_sum[DIGIT-1:0];
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/alu_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu_digit_serial
// Purpose  : Multi-cycle N-bit ALU processing one DIGIT-bit slice per clock,
//            LSB first, with valid/ready handshakes and zero/ovf/carry flags.
// Revision : 1.0
// ============================================================================
module alu_digit_serial
  import alu_digit_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_digit_serial_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              cout_q, cout_d;
  logic              w_known;

  logic [DIGIT-1:0]  w_y;
  logic              w_cout;
  logic              w_msb_sum;
  logic              w_ai_msb;
  logic              w_bi_msb;
  logic              w_ovf;
  logic              w_last;

  // Operands shift right each cycle so the slice always sees bits [DIGIT-1:0].
  alu_digit_serial_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i         (a_q[DIGIT-1:0]),
    .b_i         (b_q[DIGIT-1:0]),
    .cin_i       (carry_q),
    .ainvert_i   (ctrl_q[3]),
    .binvert_i   (ctrl_q[2]),
    .operation_i (ctrl_q[1:0]),
    .y_o         (w_y),
    .cout_o      (w_cout),
    .msb_sum_o   (w_msb_sum)
  );

  assign w_ai_msb = a_q[DIGIT-1] ^ ctrl_q[3];
  assign w_bi_msb = b_q[DIGIT-1] ^ ctrl_q[2];
  assign w_ovf    = (w_ai_msb == w_bi_msb) && (w_msb_sum != w_ai_msb);
  assign w_last   = (idx_q == IDXW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    w_known  = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          ctrl_d  = bus.ctrl;
          carry_d = bus.ctrl[2];
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = w_cout;
        idx_d   = idx_q + 1'b1;
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(w_y) << (WIDTH - DIGIT));
        if (w_last) begin
          state_d  = S_DONE;
          idx_d    = '0;
          result_d = acc_d;
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
          case (ctrl_q)
            ALU_AND, ALU_OR, ALU_NOR: ;
            ALU_ADD, ALU_SUB: begin
              ovf_d  = w_ovf;
              cout_d = w_cout;
            end
            ALU_SLT: begin
              result_d = {{(WIDTH-1){1'b0}}, w_msb_sum ^ w_ovf};
              ovf_d    = w_ovf;
              cout_d   = w_cout;
            end
            default: begin
              result_d = '0;
              w_known  = 1'b0;
            end
          endcase
          zero_d = w_known && (result_d == '0);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_digit_serial
// Purpose  : Directed vector bench for the 4-digit ALU plus a single-pass one.
// Revision : 1.0
// ============================================================================
module tb_alu_digit_serial;
  import alu_digit_serial_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        c;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_digit_serial_if #(.WIDTH(32)) bus  ();
  alu_digit_serial_if #(.WIDTH(32)) bus1 ();

  alu_digit_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_digit_serial #(.WIDTH(32), .DIGIT(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, output int lat);
    int n;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.ctrl     = ctrl;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Scramble the inputs once accepted; the captured copies must be used.
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = a ^ b ^ 32'h5A5A_A5A5;
    bus.ctrl     = 4'b0001;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    total = 0;
    bad   = 0;

    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, ALU_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000005, 32'h00000005, ALU_SUB, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, ALU_SLT, 32'h00000001, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h7FFFFFFF, 32'h80000000, ALU_SLT, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h00000000, ALU_NOR, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, ALU_AND, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h12340000, 32'h00005678, ALU_OR,  32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, ALU_ADD, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h00000000, 32'h00000001, ALU_SUB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h80000000, 32'h00000001, ALU_SUB, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{32'h00000005, 32'h00000003, 4'b0011, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h000000FF, 32'h00000001, ALU_ADD, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h00000003, 32'h00000005, ALU_SLT, 32'h00000001, 1'b0, 1'b0, 1'b0};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.ctrl       = '0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.ctrl      = '0;
    bus1.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result",    bus.result,         32'd0);
    chk("rst zero",      32'(bus.zero),      32'd0);
    chk("rst overflow",  32'(bus.overflow),  32'd0);
    chk("rst carry",     32'(bus.carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].ctrl, lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d zero", i), 32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].o));
      chk($sformatf("v%0d carry", i), 32'(bus.carry_out), 32'(vecs[i].c));
      consume();
    end

    // Backpressure: 0x10 - 3 = 0xD held in DONE for three cycles.
    issue(32'h00000010, 32'h00000003, ALU_SUB, lat);
    chk("bp latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp%0d result", k), bus.result, 32'h0000000D);
      chk($sformatf("bp%0d carry", k), 32'(bus.carry_out), 32'd1);
      chk($sformatf("bp%0d overflow", k), 32'(bus.overflow), 32'd0);
      @(posedge clk);
      #1;
    end
    consume();
    chk("bp in_ready after", 32'(bus.in_ready), 32'd1);
    chk("bp out_valid after", 32'(bus.out_valid), 32'd0);

    // Reset while RUN is on digit index 2.
    @(negedge clk);
    bus.a = 32'h00000005; bus.b = 32'h00000006; bus.ctrl = ALU_ADD; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid in_ready busy", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst result",    bus.result,         32'd0);
    chk("mid rst carry",     32'(bus.carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid no out_valid", 32'(bus.out_valid), 32'd0);
    issue(32'h00000003, 32'h00000004, ALU_ADD, lat);
    chk("post rst latency", 32'(lat), 32'd4);
    chk("post rst result",  bus.result, 32'h00000007);
    chk("post rst zero",    32'(bus.zero), 32'd0);
    consume();

    // Single-pass instance: one edge from accept to out_valid.
    @(negedge clk);
    bus1.a = 32'h7FFFFFFF; bus1.b = 32'h80000000; bus1.ctrl = ALU_SLT; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d32 slt latency",  32'(lat), 32'd1);
    chk("d32 slt result",   bus1.result, 32'h00000000);
    chk("d32 slt zero",     32'(bus1.zero), 32'd1);
    chk("d32 slt overflow", 32'(bus1.overflow), 32'd1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    bus1.a = 32'h7FFFFFFF; bus1.b = 32'h00000001; bus1.ctrl = ALU_ADD; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d32 add latency",  32'(lat), 32'd1);
    chk("d32 add result",   bus1.result, 32'h80000000);
    chk("d32 add overflow", 32'(bus1.overflow), 32'd1);
    chk("d32 add carry",    32'(bus1.carry_out), 32'd0);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
